// File: rtl/subtractor_pkg.sv
// rtl/subtractor_pkg.sv - shared types for the bit-serial subtractor
package subtractor_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial d = a - b with start/busy/done handshake
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_rd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_rd_next;

  full_subtractor u_cell (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB; written as a shift so WIDTH=1 needs no slice.
  assign w_rd_next = (r_rd >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rd    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_rd    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_rd  <= w_rd_next;
          r_br  <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          // Last bit: publish result including this edge's difference and borrow.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_d     <= w_rd_next;
            r_bout  <= w_bout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing `d = a - b` over `WIDTH`-bit unsigned operands, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the sequential successor to the lab's one-bit combinational subtractor. It sits between operand registers and a result consumer under a start/busy/done handshake. It trades `WIDTH` cycles of latency for one-bit datapath hardware.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the edge that accepts `start`.
- `b`  in  WIDTH  subtrahend; sampled on the same edge as `a`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `d`/`bout` are valid from this cycle on.
- `d`  out  WIDTH  difference `(a - b) mod 2^WIDTH`.
- `bout`  out  1  final borrow; 1 iff `a < b` as unsigned values.

## Operation
- The state machine has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `start`=1 at a rising edge loads `a` and `b` into internal shift registers `ra` and `rb`.
  - The same edge clears the borrow FF and the bit counter, and moves to SHIFT.
  - `start`=0 stays in IDLE.
- **SHIFT**, each edge:
  - Bit cell inputs are `ra[0]`, `rb[0]` and borrow `br`.
  - Difference bit is `ra[0]^rb[0]^br`.
  - Next borrow is `(~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br)`.
  - The difference bit shifts into the MSB of internal result register `rd`; `ra`, `rb` and `rd` shift right by one.
  - The counter increments.
  - On the edge where the counter reaches `WIDTH`, the state moves to DONE, and `d` and `bout` load the final `rd` and borrow (including that edge's bit).
- **DONE**: `done`=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
- `start` asserted in SHIFT or DONE is ignored; it is not queued.
- `d` and `bout` change only on entry to DONE. They hold their value through IDLE and the next SHIFT until the next completion.
- The counter is `$clog2(WIDTH+1)` bits wide, so it does not wrap before `WIDTH`.
- For `WIDTH`=1, the block behaves as a registered half subtractor: `d = a^b`, `bout = ~a&b`.

## Timing
- **Reset** (asynchronous, takes effect immediately, also mid-operation):
  - State is IDLE; `busy`=0, `done`=0, `d`=0, `bout`=0.
  - Internal shift registers, borrow and counter are 0.
  - Any in-flight operation is abandoned, with no `done`.
- Let E0 be the edge that accepts `start`:
  - `busy`=1 from E0 through edge E0+`WIDTH`.
  - `done`=1 in the cycle after edge E0+`WIDTH`.
  - Total latency is `WIDTH`+1 edges from E0 to the `done` cycle's end.
- **Minimum initiation interval** is `WIDTH`+2 cycles. A `start` held continuously is re-accepted on the first edge in IDLE, which is the edge after `done`.
- **Outputs** are registered only, with no combinational path from inputs to outputs.
- **Operand stability**: `a` and `b` may change freely after E0.

## Structure
- Shared package `subtractor_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t`.
  - Any future mode constants.
- Sub-module `full_subtractor` (inputs `a`, `b`, `bin`; outputs `d`, `bout`) is purely combinational and instantiated once as the bit cell.
- The top level contains the FSM, shift registers, borrow FF, counter and output registers.

## Test plan
- Reset, then `WIDTH`=8, `a`=5, `b`=3, `start` pulse → `busy` high 8 cycles, `done` pulse on cycle 9, `d`=8'h02, `bout`=0.
- `a`=3, `b`=5 → `d`=8'hFE, `bout`=1. `a`=8'hFF, `b`=8'hFF → `d`=0, `bout`=0. `a`=0, `b`=8'hFF → `d`=8'h01, `bout`=1.
- While `busy` after a 5-3 start, assert `start` with `a`=9, `b`=1 → ignored; result stays 2 and exactly one `done` pulse occurs. Holding `start` high gives back-to-back results with `done` every 10 cycles.
- Assert `reset` mid-SHIFT (cycle 4 of 8) → all outputs 0 immediately, no `done`. A new start then computes 200-100 → `d`=100, `bout`=0.
- Exhaustive sweep with `WIDTH`=4 over all 256 (`a`,`b`) pairs → `d == (a-b)&4'hF` and `bout == (a<b)`. Latency is always 5 edges from accept to `done`.
- `WIDTH`=1 over all 4 input pairs → matches half subtractor truth table: 00→0/0, 01→1/1, 10→1/0, 11→0/0.
